// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (instruction fetch vs data) with speculative-kill of stale fetches.
// Optional MEM_ARBITER_ROUND_ROBIN_EN: round-robin on ties instead of fixed data-over-instruction priority.
package mem_arbiter_pkg;
   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_spec;
      logic        mem_instr;
      logic [1:0]  mem_mode;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic        mem_error;
      logic [31:0] mem_rdata;
   } mem_out_type;
endpackage

module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  memory_in,
   input  mem_out_type memory_out
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t     state_q, state_d;
   mem_in_type slot_i_q, slot_i_d;
   mem_in_type slot_d_q, slot_d_d;
   mem_in_type mem_q, mem_d;
   logic       discard_q, discard_d;
   mem_in_type eff_i, eff_d;
   logic       resp, kill, free, gnt_i, gnt_d, prefer_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic       last_d_q, last_d_d;
`endif

   assign resp = memory_out.mem_ready | memory_out.mem_error;
   assign kill = (state_q == BUSY_I) & imem_in.mem_valid & imem_in.mem_spec;
   // The response cycle already counts as idle, so a pending request issues right behind it.
   assign free = (state_q == IDLE) | resp;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   assign prefer_d = ~last_d_q;
`else
   assign prefer_d = 1'b1;
`endif

   always_comb begin
      eff_i     = imem_in.mem_valid ? imem_in : slot_i_q;
      eff_d     = dmem_in.mem_valid ? dmem_in : slot_d_q;
      gnt_i     = 1'b0;
      gnt_d     = 1'b0;
      state_d   = state_q;
      mem_d     = '0;
      slot_i_d  = eff_i;
      slot_d_d  = eff_d;
      discard_d = (state_q == BUSY_I) & ~resp & (discard_q | kill);

      if (free) begin
         state_d = IDLE;
         if (eff_i.mem_valid && eff_d.mem_valid) begin
            // A fence waits for the other side to drain; two fences fall back to the tie rule.
            if (eff_i.mem_fence != eff_d.mem_fence) begin
               gnt_d = eff_i.mem_fence;
               gnt_i = eff_d.mem_fence;
            end else begin
               gnt_d = prefer_d;
               gnt_i = ~prefer_d;
            end
         end else begin
            gnt_i = eff_i.mem_valid;
            gnt_d = eff_d.mem_valid;
         end
      end

      if (gnt_d) begin
         state_d  = BUSY_D;
         mem_d    = eff_d;
         slot_d_d = '0;
      end else if (gnt_i) begin
         state_d  = BUSY_I;
         mem_d    = eff_i;
         slot_i_d = '0;
      end
   end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   always_comb begin
      last_d_d = last_d_q;
      if (gnt_d)      last_d_d = 1'b1;
      else if (gnt_i) last_d_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_d_q <= 1'b0;
      else      last_d_q <= last_d_d;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         slot_i_q  <= '0;
         slot_d_q  <= '0;
         mem_q     <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_i_q  <= slot_i_d;
         slot_d_q  <= slot_d_d;
         mem_q     <= mem_d;
         discard_q <= discard_d;
      end
   end

   assign memory_in = mem_q;
   assign imem_out  = ((state_q == BUSY_I) && !discard_q && !kill) ? memory_out : '0;
   assign dmem_out  = (state_q == BUSY_D) ? memory_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a per-requester pending/owner reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   mem_in_type  imem_in, dmem_in, memory_in;
   mem_out_type imem_out, dmem_out, memory_out;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .imem_in    (imem_in),
      .imem_out   (imem_out),
      .dmem_in    (dmem_in),
      .dmem_out   (dmem_out),
      .memory_in  (memory_in),
      .memory_out (memory_out)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: index 0 = instruction requester, 1 = data requester.
   mem_in_type pend [2];
   int         own;
   bit         discard;
   int         last;
   mem_in_type exp_mem;
   int         cyc, resp_at, lat_force, ntx;
   bit         err_force;
   mem_in_type z;

   task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic mem_in_type mk(input bit instr, input bit [31:0] addr, input bit spec,
                                     input bit fence, input bit [3:0] wstrb, input bit [31:0] wdata);
      mem_in_type r;
      r.mem_valid = 1'b1;
      r.mem_fence = fence;
      r.mem_spec  = spec;
      r.mem_instr = instr;
      r.mem_mode  = 2'b11;
      r.mem_addr  = addr;
      r.mem_wdata = wdata;
      r.mem_wstrb = wstrb;
      return r;
   endfunction

   function automatic int pick();
      bit pi = pend[0].mem_valid;
      bit pd = pend[1].mem_valid;
      if (pi && pd) begin
         if (pend[0].mem_fence && !pend[1].mem_fence) return 1;
         if (pend[1].mem_fence && !pend[0].mem_fence) return 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         return (last == 1) ? 0 : 1;
`else
         return 1;
`endif
      end
      if (pd) return 1;
      if (pi) return 0;
      return -1;
   endfunction

   task automatic model_reset();
      pend[0] = '0; pend[1] = '0;
      own = -1; discard = 0; last = 0; exp_mem = '0;
   endtask

   task automatic note_issue();
      if (exp_mem.mem_valid) begin
         resp_at   = cyc + ((lat_force > 0) ? lat_force : int'($urandom_range(1, 3)));
         lat_force = 0;
         ntx++;
         $display("txn %0d cyc=%0d %s addr=%h wstrb=%h fence=%0d", ntx, cyc,
                  exp_mem.mem_instr ? "I" : "D", exp_mem.mem_addr, exp_mem.mem_wstrb, exp_mem.mem_fence);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick(input mem_in_type ireq, input mem_in_type dreq);
      mem_out_type mo, ei, ed;
      mem_in_type  req [2];
      bit          resp, kill;
      int          w;
      chk("memory_in", memory_in, exp_mem);
      note_issue();
      mo.mem_rdata = $urandom;
      mo.mem_ready = 1'b0;
      mo.mem_error = 1'b0;
      if (cyc == resp_at) begin
         if (err_force || $urandom_range(0, 7) == 0) mo.mem_error = 1'b1;
         else                                        mo.mem_ready = 1'b1;
         err_force = 0;
         resp_at   = -1;
      end
      imem_in = ireq; dmem_in = dreq; memory_out = mo;
      #1;
      resp = mo.mem_ready | mo.mem_error;
      kill = (own == 0) && ireq.mem_valid && ireq.mem_spec;
      ei   = (own == 0 && !discard && !kill) ? mo : '0;
      ed   = (own == 1) ? mo : '0;
      chk("imem_out", {40'b0, imem_out}, {40'b0, ei});
      chk("dmem_out", {40'b0, dmem_out}, {40'b0, ed});
      req[0] = ireq; req[1] = dreq;
      for (int r = 0; r < 2; r++) if (req[r].mem_valid) pend[r] = req[r];
      discard = (own == 0 && !resp) ? (discard || kill) : 1'b0;
      exp_mem = '0;
      if (own < 0 || resp) begin
         own = -1;
         w   = pick();
         if (w >= 0) begin
            exp_mem = pend[w];
            pend[w] = '0;
            own     = w;
            last    = w;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      chk("memory_in", memory_in, exp_mem);
      note_issue();
      imem_in = '0; dmem_in = '0;
      memory_out = '{mem_ready: 1'b1, mem_error: 1'b0, mem_rdata: 32'hCAFE_F00D};
      rst = 1'b0;
      #1;
      chk("rst_memory_in", memory_in, 74'd0);
      chk("rst_imem_out", {40'b0, imem_out}, 74'd0);
      chk("rst_dmem_out", {40'b0, dmem_out}, 74'd0);
      model_reset();
      cyc++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(z, z);
   endtask

   initial begin
      z = '0;
      imem_in = '0; dmem_in = '0; memory_out = '0;
      cyc = 0; resp_at = -1; lat_force = 0; err_force = 0; ntx = 0;
      model_reset();
      rst = 1'b0;
      #1;
      chk("init_memory_in", memory_in, 74'd0);
      chk("init_imem_out", {40'b0, imem_out}, 74'd0);
      chk("init_dmem_out", {40'b0, dmem_out}, 74'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Single fetch: issue next cycle, ready two cycles after issue.
      lat_force = 2;
      tick(mk(1, 32'h0000_0100, 0, 0, 4'h0, 0), z);
      idle(5);

      // Simultaneous requests.
      tick(mk(1, 32'h0000_0200, 0, 0, 4'h0, 0), mk(0, 32'h8000_0000, 0, 0, 4'h0, 0));
      idle(8);

      // Speculative kill of an in-flight fetch.
      lat_force = 3;
      tick(mk(1, 32'h0000_0300, 0, 0, 4'h0, 0), z);
      tick(z, z);
      tick(mk(1, 32'h0000_0400, 1, 0, 4'h0, 0), z);
      idle(8);

      // Store that returns an error.
      err_force = 1;
      tick(z, mk(0, 32'h0000_0010, 0, 0, 4'hF, 32'h1234_5678));
      idle(6);

      // Reset while a data access is in flight; its ready arrives afterwards.
      lat_force = 2;
      tick(z, mk(0, 32'h0000_0020, 0, 0, 4'h0, 0));
      reset_dut();
      idle(3);
      tick(mk(1, 32'h0000_0500, 0, 0, 4'h0, 0), z);
      idle(5);

      // Fence behind an in-flight load.
      lat_force = 3;
      tick(z, mk(0, 32'h0000_0040, 0, 0, 4'h0, 0));
      tick(z, z);
      tick(mk(1, 32'h0000_0600, 0, 1, 4'h0, 0), z);
      idle(8);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         mem_in_type ir, dr;
         ir = z; dr = z;
         if ($urandom_range(0, 3) == 0)
            ir = mk(1, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 4'h0, 0);
         if ($urandom_range(0, 3) == 0)
            dr = mk(0, $urandom, 0, ($urandom_range(0, 7) == 0), 4'($urandom), $urandom);
         if ($urandom_range(0, 499) == 0) reset_dut();
         else                             tick(ir, dr);
      end
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the fetch stage's instruction fetch-buffer request and its data-memory request. Captures each single-cycle request into a per-requester pending slot and issues one access at a time to the shared port. Routes the response back to the requester that owns the in-flight access. Drops responses to instruction accesses superseded by a speculative redirect (trap, mret, jump).

## Interface
No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_in  in  mem_in_type  instruction request from the fetch buffer; mem_instr=1
- imem_out  out  mem_out_type  instruction response: mem_ready, mem_error, mem_rdata
- dmem_in  in  mem_in_type  data request from the fetch stage; mem_wstrb=0 means load
- dmem_out  out  mem_out_type  data response
- memory_in  out  mem_in_type  request to the shared memory
- memory_out  in  mem_out_type  response from the shared memory

## Operation
- Request protocol
  - A request is any cycle with mem_valid=1.
  - All request fields are captured into the requester's pending slot: valid, fence, spec, instr, mode, addr, wdata, wstrb.
  - A new request to an occupied slot overwrites it. Latest wins.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE
  - If a slot is pending, select it, drive memory_in from that slot with mem_valid=1 for exactly one cycle, clear the slot, and go to BUSY_I or BUSY_D.
  - If both slots are pending: with the config macro off, data wins. With it on, round-robin applies (see Configuration).
- BUSY_x
  - memory_in.mem_valid=0.
  - On memory_out.mem_ready or mem_error, return to IDLE.
- Response routing
  - Combinational: x_out = memory_out only while state=BUSY_x. The other requester sees all-zero.
- Speculative kill
  - Applies in BUSY_I when imem_in.mem_valid=1 and imem_in.mem_spec=1.
  - Set the discard flag. The in-flight instruction response is suppressed: imem_out stays zero.
  - The new request goes to the pending slot as normal.
  - The discard flag clears when the state leaves BUSY_I.
- Speculative request arriving in IDLE: normal issue, nothing to discard.
- Fence
  - mem_fence is carried with its request.
  - A fence request is issued only when the other slot is empty and the state is IDLE.
- Data error: the memory_out.mem_error pulse is routed exactly as mem_ready is.
- Request arriving on a response cycle: captured into its slot, issued the following cycle (IDLE).

## Timing
- Reset (rst=0, async)
  - state=IDLE, both slots empty, discard=0, last-grant=instruction.
  - memory_in all-zero; imem_out and dmem_out all-zero.
- memory_in is registered. Request at cycle N with the arbiter IDLE and no competition gives memory_in.mem_valid=1 at N+1.
- Responses have zero added latency: memory_out ready at cycle M appears on the owner's output at M.
- Earliest memory response is the cycle after issue.
- Back-to-back sequence: response at M, next issue at M+1, so each access takes at least 2 cycles.
- Reset asserted mid-access
  - Everything clears immediately.
  - A memory response arriving after release while IDLE is ignored: both outputs stay zero.
- Simultaneous requests from both requesters in the same cycle: both captured, issue order per priority rule.

## Configuration
- MEM_ARBITER_ROUND_ROBIN_EN
  - Defined: on a tie in IDLE, grant the requester not granted last. The last-grant register updates on every issue.
  - Undefined: fixed priority, data over instruction. The last-grant register is not implemented.
- Non-tie behaviour is identical in both builds.

## Test plan
- Single fetch
  - Stimulus: imem request addr=0x0000_0100 at cycle 1; memory ready with rdata=0x0000_0013 at cycle 4.
  - Required: memory_in.mem_valid=1, addr=0x100, mem_instr=1 at cycle 2; imem_out.mem_ready=1, rdata=0x13 at cycle 4; dmem_out stays zero.
- Simultaneous requests
  - Stimulus: imem addr=0x200 and dmem load addr=0x8000_0000 both at cycle 1.
  - Required, macro off: data issued at cycle 2, instruction issued the cycle after the data response.
  - Required, macro on with last grant = data: instruction issued first.
- Speculative kill
  - Stimulus: imem addr=0x300 issued; during BUSY_I, imem spec request addr=0x400; memory answers 0x300 with rdata=0xDEAD_BEEF.
  - Required: imem_out stays zero on that response; 0x400 issued the next cycle and its response delivered.
- Store with error
  - Stimulus: dmem addr=0x10, wdata=0x1234_5678, wstrb=4'hF; memory returns mem_error=1.
  - Required: memory_in wstrb=4'hF; dmem_out.mem_error=1 for exactly one cycle; imem_out stays zero.
- Reset mid-access
  - Stimulus: rst=0 for one cycle during BUSY_D; memory ready arrives after reset release.
  - Required: all outputs zero immediately on reset; late ready not routed to either requester; next request issues normally.
- Fence ordering
  - Stimulus: dmem load pending/in flight; imem fence request arrives.
  - Required: fence issued only after the data response, with memory_in.mem_fence=1.
